micro_sequencer: RTL and testbench

Registered microprogram sequencer for the multicycle MIPS control unit. Each cycle it selects the next control state from the current microinstruction's sequencing field. Sources are increment, opcode dispatch, absolute jump, conditional jump, or call/return through a small return stack. Its state output addresses the control ROM; it replaces the purely combinational dispatch path. It adds memory-wait stalling, illegal-instruction detection and parametrised state width and stack depth.

---
 rtl/micro_seq_pkg.sv | 93 +++++++++
 rtl/micro_sequencer_if.sv | 30 +++
 rtl/micro_sequencer_instr_dispatch.sv | 77 +++++++
 rtl/micro_sequencer.sv | 115 +++++++++++
 tb/tb_micro_sequencer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/micro_seq_pkg.sv
// Shared constants for the microprogram sequencer: sequencing-field codes,
// control-state numbers, MIPS opcode/funct encodings and parameter defaults.
package micro_seq_pkg;

  localparam int DEF_STATE_W     = 7;
  localparam int DEF_STACK_DEPTH = 2;
  localparam int DEF_FETCH_STATE = 1;

  // Highest state number for a given width; used as the illegal-instruction trap.
  function automatic int max_state(input int width);
    return (2 ** width) - 1;
  endfunction

  localparam int DEF_ILLEGAL_STATE = max_state(DEF_STATE_W);

  localparam logic [2:0] SEQ_INC      = 3'b000;
  localparam logic [2:0] SEQ_DISPATCH = 3'b001;
  localparam logic [2:0] SEQ_JUMP     = 3'b010;
  localparam logic [2:0] SEQ_CJUMP    = 3'b011;
  localparam logic [2:0] SEQ_CALL     = 3'b100;
  localparam logic [2:0] SEQ_RET      = 3'b101;
  localparam logic [2:0] SEQ_FETCH    = 3'b110;

  localparam int ST_ADDU  = 6;
  localparam int ST_STORE = 7;
  localparam int ST_BEQ   = 11;
  localparam int ST_LOAD  = 13;
  localparam int ST_SUBU  = 17;
  localparam int ST_ADDIU = 18;
  localparam int ST_SLTU  = 19;
  localparam int ST_SLTIU = 20;
  localparam int ST_CLO   = 21;
  localparam int ST_CLZ   = 22;
  localparam int ST_AND   = 23;
  localparam int ST_ANDI  = 24;
  localparam int ST_OR    = 25;
  localparam int ST_ORI   = 26;
  localparam int ST_XOR   = 27;
  localparam int ST_XORI  = 28;
  localparam int ST_NOR   = 29;
  localparam int ST_LUI   = 30;
  localparam int ST_SLL   = 31;
  localparam int ST_SRA   = 32;
  localparam int ST_SRL   = 33;
  localparam int ST_MOVN  = 34;
  localparam int ST_MOVZ  = 35;
  localparam int ST_BGEZ  = 37;
  localparam int ST_BGTZ  = 39;
  localparam int ST_BNE   = 41;
  localparam int ST_BLEZ  = 42;
  localparam int ST_JR    = 44;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MOVZ = 6'h0A;
  localparam logic [5:0] FN_MOVN = 6'h0B;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_CLZ  = 6'h20;
  localparam logic [5:0] FN_CLO  = 6'h21;

  localparam logic [4:0] RT_BGEZ = 5'h01;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-unit side of the sequencer: microinstruction fields and instruction
// in, current control state and return-stack status out.
interface micro_sequencer_if #(
  parameter int STATE_W     = 7,
  parameter int STACK_DEPTH = 2
) ();
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [31:0]        instr;
  logic [2:0]         seq_mode;
  logic [STATE_W-1:0] target;
  logic               cond;
  logic               wait_moc;
  logic               moc;
  logic [STATE_W-1:0] state_o;
  logic               illegal_o;
  logic [LVL_W-1:0]   stk_level_o;
  logic               stk_ovf_o;
  logic               stk_unf_o;

  modport master (
    output instr, seq_mode, target, cond, wait_moc, moc,
    input  state_o, illegal_o, stk_level_o, stk_ovf_o, stk_unf_o
  );

  modport slave (
    input  instr, seq_mode, target, cond, wait_moc, moc,
    output state_o, illegal_o, stk_level_o, stk_ovf_o, stk_unf_o
  );
endinterface

// File: rtl/micro_sequencer_instr_dispatch.sv
// Combinational opcode dispatch: maps an instruction word to the first control
// state of its microroutine, flagging words that match no table entry.
module instr_dispatch
  import micro_seq_pkg::*;
#(
  parameter int STATE_W = DEF_STATE_W
) (
  input  logic [31:0]        instr,
  output logic [STATE_W-1:0] entry,
  output logic               legal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       unused_fields;
  int         entry_num;

  assign opcode        = instr[31:26];
  assign rt            = instr[20:16];
  assign funct         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    entry_num = 0;
    legal     = 1'b1;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU: entry_num = ST_ADDU;
          FN_SUBU: entry_num = ST_SUBU;
          FN_SLTU: entry_num = ST_SLTU;
          FN_AND:  entry_num = ST_AND;
          FN_OR:   entry_num = ST_OR;
          FN_XOR:  entry_num = ST_XOR;
          FN_NOR:  entry_num = ST_NOR;
          FN_SLL:  entry_num = ST_SLL;
          FN_SRA:  entry_num = ST_SRA;
          FN_SRL:  entry_num = ST_SRL;
          FN_MOVN: entry_num = ST_MOVN;
          FN_MOVZ: entry_num = ST_MOVZ;
          FN_JR:   entry_num = ST_JR;
          default: legal = 1'b0;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          FN_CLO:  entry_num = ST_CLO;
          FN_CLZ:  entry_num = ST_CLZ;
          default: legal = 1'b0;
        endcase
      end
      // REGIMM shares one opcode across several branches; rt picks BGEZ.
      OP_REGIMM: begin
        if (rt == RT_BGEZ) entry_num = ST_BGEZ;
        else               legal = 1'b0;
      end
      OP_ADDIU: entry_num = ST_ADDIU;
      OP_SLTIU: entry_num = ST_SLTIU;
      OP_ANDI:  entry_num = ST_ANDI;
      OP_ORI:   entry_num = ST_ORI;
      OP_XORI:  entry_num = ST_XORI;
      OP_LUI:   entry_num = ST_LUI;
      OP_BEQ:   entry_num = ST_BEQ;
      OP_BNE:   entry_num = ST_BNE;
      OP_BLEZ:  entry_num = ST_BLEZ;
      OP_BGTZ:  entry_num = ST_BGTZ;
      OP_SB, OP_SH, OP_SW:                  entry_num = ST_STORE;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:  entry_num = ST_LOAD;
      default: legal = 1'b0;
    endcase
    entry = STATE_W'(entry_num);
  end

endmodule

// File: rtl/micro_sequencer.sv
// Registered microprogram sequencer: picks the next control-ROM address from
// the sequencing field, with dispatch, call/return stack and memory stall.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int STATE_W       = DEF_STATE_W,
  parameter int STACK_DEPTH   = DEF_STACK_DEPTH,
  parameter int FETCH_STATE   = DEF_FETCH_STATE,
  parameter int ILLEGAL_STATE = max_state(STATE_W)
) (
  input logic              clk,
  input logic              rst_n,
  micro_sequencer_if.slave bus
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] inc_state;
  logic [STATE_W-1:0] disp_entry;
  logic               disp_legal;
  logic               illegal_q, illegal_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [LVL_W-1:0]   level_q;
  logic               push, pop;
  logic               stall;
  logic               stk_full, stk_empty;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [STATE_W-1:0] stack_mem [STACK_DEPTH];

  instr_dispatch #(
    .STATE_W(STATE_W)
  ) u_dispatch (
    .instr(bus.instr),
    .entry(disp_entry),
    .legal(disp_legal)
  );

  assign inc_state = state_q + STATE_W'(1);
  assign stall     = bus.wait_moc & ~bus.moc;
  assign stk_full  = (level_q == LVL_W'(STACK_DEPTH));
  assign stk_empty = (level_q == '0);
  assign wr_ptr    = PTR_W'(level_q);
  assign rd_ptr    = PTR_W'(level_q - LVL_W'(1));

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (!stall) begin
      case (bus.seq_mode)
        SEQ_INC:   state_d = inc_state;
        SEQ_DISPATCH: begin
          state_d   = disp_legal ? disp_entry : STATE_W'(ILLEGAL_STATE);
          illegal_d = ~disp_legal;
        end
        SEQ_JUMP:  state_d = bus.target;
        SEQ_CJUMP: state_d = bus.cond ? bus.target : inc_state;
        // A call into a full stack still jumps; only the return address is lost.
        SEQ_CALL: begin
          state_d = bus.target;
          if (stk_full) ovf_d = 1'b1;
          else          push  = 1'b1;
        end
        SEQ_RET: begin
          if (stk_empty) begin
            unf_d   = 1'b1;
            state_d = STATE_W'(FETCH_STATE);
          end else begin
            pop     = 1'b1;
            state_d = stack_mem[rd_ptr];
          end
        end
        default:   state_d = STATE_W'(FETCH_STATE);
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      if (push)     level_q <= level_q + LVL_W'(1);
      else if (pop) level_q <= level_q - LVL_W'(1);
    end
  end

  // NOTE: the stack array has no reset; clearing level_q is what empties it,
  // and entries are always written before they can be read back.
  always_ff @(posedge clk) begin
    if (push) stack_mem[wr_ptr] <= inc_state;
  end

  assign bus.state_o     = state_q;
  assign bus.illegal_o   = illegal_q;
  assign bus.stk_level_o = level_q;
  assign bus.stk_ovf_o   = ovf_q;
  assign bus.stk_unf_o   = unf_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a 7-bit instance for the main sequencing
// behaviour and a 4-bit instance for wrap-around and asynchronous reset.
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  typedef struct {
    int          sel;
    int          due;
    logic [6:0]  st;
    logic        ill;
    logic [1:0]  lvl;
    logic        ovf;
    logic        unf;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur;
  logic [6:0] a_st;
  logic       a_ill, a_ovf, a_unf;
  logic [1:0] a_lvl;

  micro_sequencer_if #(.STATE_W(7), .STACK_DEPTH(2)) ifa ();
  micro_sequencer_if #(.STATE_W(4), .STACK_DEPTH(2)) ifb ();

  micro_sequencer #(.STATE_W(7), .STACK_DEPTH(2), .FETCH_STATE(1), .ILLEGAL_STATE(127)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  micro_sequencer #(.STATE_W(4), .STACK_DEPTH(2), .FETCH_STATE(1), .ILLEGAL_STATE(15)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares queued expectations just after each falling edge, and
  // also right after rst4_n falls so asynchronous reset is observed mid-cycle.
  always begin
    @(negedge clk or negedge rst4_n);
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      if (cur.sel == 0) begin
        a_st = ifa.state_o;  a_ill = ifa.illegal_o; a_lvl = ifa.stk_level_o;
        a_ovf = ifa.stk_ovf_o; a_unf = ifa.stk_unf_o;
      end else begin
        a_st = {3'b000, ifb.state_o}; a_ill = ifb.illegal_o; a_lvl = ifb.stk_level_o;
        a_ovf = ifb.stk_ovf_o; a_unf = ifb.stk_unf_o;
      end
      checks++;
      if (cur.due != cyc || a_st !== cur.st || a_ill !== cur.ill || a_lvl !== cur.lvl ||
          a_ovf !== cur.ovf || a_unf !== cur.unf) begin
        errors++;
        $display("FAIL %s (cycle %0d, due %0d): got state=%0d ill=%0b lvl=%0d ovf=%0b unf=%0b, expected state=%0d ill=%0b lvl=%0d ovf=%0b unf=%0b",
                 cur.name, cyc, cur.due, a_st, a_ill, a_lvl, a_ovf, a_unf,
                 cur.st, cur.ill, cur.lvl, cur.ovf, cur.unf);
      end
    end
  end

  task automatic push_exp(input int sel, input int due, input logic [6:0] es, input logic ei,
                          input logic [1:0] el, input logic eo, input logic eu, input string nm);
    exp_t e;
    e.sel = sel; e.due = due; e.st = es; e.ill = ei; e.lvl = el;
    e.ovf = eo; e.unf = eu; e.name = nm;
    sb.push_back(e);
  endtask

  // Drive one microinstruction, queue the state expected after the next edge.
  task automatic step(input int sel, input logic [2:0] mode, input logic [6:0] tgt,
                      input logic [31:0] ins, input logic c, input logic w, input logic m,
                      input logic [6:0] es, input logic ei, input logic [1:0] el,
                      input logic eo, input logic eu, input string nm);
    if (sel == 0) begin
      ifa.seq_mode = mode; ifa.target = tgt; ifa.instr = ins;
      ifa.cond = c; ifa.wait_moc = w; ifa.moc = m;
    end else begin
      ifb.seq_mode = mode; ifb.target = tgt[3:0]; ifb.instr = ins;
      ifb.cond = c; ifb.wait_moc = w; ifb.moc = m;
    end
    push_exp(sel, cyc + 1, es, ei, el, eo, eu, nm);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rst4_n = 1'b0;
    ifa.seq_mode = SEQ_INC; ifa.target = '0; ifa.instr = '0;
    ifa.cond = 1'b0; ifa.wait_moc = 1'b0; ifa.moc = 1'b0;
    ifb.seq_mode = SEQ_INC; ifb.target = '0; ifb.instr = '0;
    ifb.cond = 1'b0; ifb.wait_moc = 1'b0; ifb.moc = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_exp(0, cyc, 7'd0, 1'b0, 2'd0, 1'b0, 1'b0, "reset_state");

    //   sel mode          tgt    instr         c  w  m  state ill lvl ovf unf
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 0, 0, 7'd1,   0, 2'd0, 0, 0, "inc_1");
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 0, 0, 7'd2,   0, 2'd0, 0, 0, "inc_2");
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 0, 0, 7'd3,   0, 2'd0, 0, 0, "inc_3");
    step(0, SEQ_FETCH,    7'd0,  32'h0,        0, 0, 0, 7'd1,   0, 2'd0, 0, 0, "fetch");
    step(0, SEQ_DISPATCH, 7'd0,  32'h00851021, 0, 0, 0, 7'd6,   0, 2'd0, 0, 0, "disp_addu");
    step(0, SEQ_DISPATCH, 7'd0,  32'hFC000000, 0, 0, 0, 7'd127, 1, 2'd0, 0, 0, "disp_illegal");
    step(0, SEQ_INC,      7'd0,  32'hFC000000, 0, 0, 0, 7'd0,   0, 2'd0, 0, 0, "inc_wrap_127");
    step(0, SEQ_DISPATCH, 7'd0,  32'h8C000000, 0, 0, 0, 7'd13,  0, 2'd0, 0, 0, "disp_lw");
    step(0, SEQ_DISPATCH, 7'd0,  32'h04010000, 0, 0, 0, 7'd37,  0, 2'd0, 0, 0, "disp_bgez");
    step(0, SEQ_DISPATCH, 7'd0,  32'h04000000, 0, 0, 0, 7'd127, 1, 2'd0, 0, 0, "disp_regimm_bad_rt");
    step(0, SEQ_DISPATCH, 7'd0,  32'h70000020, 0, 0, 0, 7'd22,  0, 2'd0, 0, 0, "disp_clz");
    step(0, SEQ_DISPATCH, 7'd0,  32'hAC000000, 0, 0, 0, 7'd7,   0, 2'd0, 0, 0, "disp_sw");
    step(0, SEQ_DISPATCH, 7'd0,  32'h34000000, 0, 0, 0, 7'd26,  0, 2'd0, 0, 0, "disp_ori");
    step(0, SEQ_DISPATCH, 7'd0,  32'h00000008, 0, 0, 0, 7'd44,  0, 2'd0, 0, 0, "disp_jr");
    step(0, 3'b111,       7'd0,  32'h0,        0, 0, 0, 7'd1,   0, 2'd0, 0, 0, "reserved_mode");
    step(0, SEQ_JUMP,     7'd11, 32'h0,        0, 0, 0, 7'd11,  0, 2'd0, 0, 0, "jump_11");
    step(0, SEQ_CJUMP,    7'd40, 32'h0,        0, 0, 0, 7'd12,  0, 2'd0, 0, 0, "cjump_not_taken");
    step(0, SEQ_JUMP,     7'd11, 32'h0,        0, 0, 0, 7'd11,  0, 2'd0, 0, 0, "jump_11b");
    step(0, SEQ_CJUMP,    7'd40, 32'h0,        1, 0, 0, 7'd40,  0, 2'd0, 0, 0, "cjump_taken");
    step(0, SEQ_JUMP,     7'd13, 32'h0,        0, 0, 0, 7'd13,  0, 2'd0, 0, 0, "jump_13");
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 1, 0, 7'd13,  0, 2'd0, 0, 0, "stall_1");
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 1, 0, 7'd13,  0, 2'd0, 0, 0, "stall_2");
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 1, 0, 7'd13,  0, 2'd0, 0, 0, "stall_3");
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 1, 1, 7'd14,  0, 2'd0, 0, 0, "moc_release");
    step(0, SEQ_DISPATCH, 7'd0,  32'hFC000000, 0, 1, 0, 7'd14,  0, 2'd0, 0, 0, "stall_masks_illegal");
    step(0, SEQ_JUMP,     7'd5,  32'h0,        0, 0, 0, 7'd5,   0, 2'd0, 0, 0, "jump_5");
    step(0, SEQ_CALL,     7'd50, 32'h0,        0, 0, 0, 7'd50,  0, 2'd1, 0, 0, "call_50");
    step(0, SEQ_CALL,     7'd60, 32'h0,        0, 0, 0, 7'd60,  0, 2'd2, 0, 0, "call_60");
    step(0, SEQ_CALL,     7'd70, 32'h0,        0, 0, 0, 7'd70,  0, 2'd2, 1, 0, "call_overflow");
    step(0, SEQ_RET,      7'd0,  32'h0,        0, 0, 0, 7'd51,  0, 2'd1, 1, 0, "ret_51");
    step(0, SEQ_RET,      7'd0,  32'h0,        0, 0, 0, 7'd6,   0, 2'd0, 1, 0, "ret_6");
    step(0, SEQ_RET,      7'd0,  32'h0,        0, 0, 0, 7'd1,   0, 2'd0, 1, 1, "ret_underflow");
    step(0, SEQ_INC,      7'd0,  32'h0,        0, 0, 0, 7'd2,   0, 2'd0, 1, 1, "flags_sticky");

    rst4_n = 1'b1;
    push_exp(1, cyc, 7'd0, 1'b0, 2'd0, 1'b0, 1'b0, "w4_reset_state");
    step(1, SEQ_DISPATCH, 7'd0,  32'hFC000000, 0, 0, 0, 7'd15,  1, 2'd0, 0, 0, "w4_disp_illegal");
    step(1, SEQ_INC,      7'd0,  32'h0,        0, 0, 0, 7'd0,   0, 2'd0, 0, 0, "w4_inc_wrap_15");
    step(1, SEQ_CALL,     7'd3,  32'h0,        0, 0, 0, 7'd3,   0, 2'd1, 0, 0, "w4_call_3");
    step(1, SEQ_INC,      7'd0,  32'h0,        0, 1, 0, 7'd3,   0, 2'd1, 0, 0, "w4_stall");

    // Assert reset between edges while stalled with one stack entry.
    @(negedge clk);
    #3;
    push_exp(1, cyc, 7'd0, 1'b0, 2'd0, 1'b0, 1'b0, "w4_async_reset");
    rst4_n = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      errors = errors + sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
